bus_arbiter8_32bits: RTL and testbench
======================================

// Module: bus_arbiter8_32bits
// PURPOSE
//   Round-robin arbiter for an 8-requester, 32-bit shared bus.
//   Picks one requester, drives the 3-bit control of the internal
//   mux8x1_32bits instance, and moves bursts of words to a single consumer
//   over a valid/ready handshake.
//   Sits between eight producer units and one shared write/result port.
// PARAMETERS
//   MAX_BURST  4   max beats per grant before a forced rotation (1..16)
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   req        in   8   req[i]=1: requester i has a word on d[i]
//   req_last   in   8   req_last[i]=1: current word of i ends its burst
//   d0..d7     in   32  requester data words, routed through mux8x1_32bits
//   out_ready  in   1   consumer accepts data_out this cycle
//   out_valid  out  1   data_out holds a valid word
//   data_out   out  32  selected word (mux8x1_32bits result)
//   sel        out  3   mux control = index of current or last grantee
//   grant      out  8   one-hot grant, all zero when idle
//   ack        out  8   ack[i]=1 for one cycle when requester i's beat transfers
//   lock       in   8   only with ARB_LOCK_EN, see CONFIGURATION
// BEHAVIOUR
//   - Reset values: state=IDLE, grant=0, out_valid=0, ack=0, sel=0,
//     rr pointer ptr=0, beat_cnt=0.
//     Reset is asserted asynchronously and released synchronously.
//   - Reset mid-burst aborts the burst. No ack is issued for it.
//   - States: IDLE, BUSY.
//   - IDLE: if |req, pick the first i with req[i]=1, searching ptr, ptr+1, ... mod 8.
//     On the next edge: grant=onehot(i), sel=i, out_valid=1, state=BUSY.
//     Request-to-valid latency is 1 cycle.
//   - BUSY: out_valid=1 and data_out=d[sel], combinational through the mux.
//   - Transfer: out_valid & out_ready.
//     In that cycle ack[sel]=1 (combinational) and beat_cnt++.
//   - Release: on a transfer with req_last[sel]=1 or beat_cnt==MAX_BURST-1.
//     ptr <= sel+1 mod 8, beat_cnt <= 0.
//     If any req (masked with ~ack) is set, re-arbitrate from the new ptr and
//     grant on the same edge, so there is no idle bubble. Otherwise go to IDLE.
//   - The releasing requester can win again only if no other requester is asking,
//     because it has lowest priority after ptr moves.
//   - Abort: req[sel] falls while BUSY with no transfer (protocol violation).
//     Next edge: grant=0, out_valid=0, ptr <= sel+1, IDLE. No ack.
//   - out_valid never falls while out_ready=0, except on abort or reset.
//   - sel holds its last value in IDLE, so the mux output stays stable.
//   - ptr wraps 7 -> 0.
//   - beat_cnt is $clog2(MAX_BURST)+1 bits wide and saturates at release.
// CONFIGURATION
//   ARB_LOCK_EN defined:
//     - lock port is present.
//     - If lock[sel]=1 at release time, the MAX_BURST limit is ignored.
//     - The grant is held until a transfer with req_last[sel]=1 and lock[sel]=0.
//   ARB_LOCK_EN undefined:
//     - No lock port.
//     - Every burst is capped at MAX_BURST.
// STRUCTURE
//   - Package bus_arb_pkg holds:
//     - NREQ=8 and SELW=3
//     - the state enum {IDLE, BUSY}
//     - the onehot/index helper function
//   - Sub-module rr_pick8: combinational rotating priority encoder.
//     Inputs: req[7:0], ptr[2:0]. Outputs: found, idx[2:0].
//   - Instantiates existing mux8x1_32bits for the datapath, with control=sel.
// TESTING
//   - Reset: hold rst_n=0 -> grant=0, out_valid=0, sel=0.
//     Release with req=8'h10 -> after 1 cycle grant=8'h10, sel=4, valid=1.
//   - Fairness: req=8'hFF, req_last=8'hFF, out_ready=1 for 16 cycles.
//     -> sel walks 0,1,...,7,0,...; each ack is one-hot; valid never drops.
//   - Burst cap: MAX_BURST=4, req=8'h01, req_last=0, out_ready=1.
//     -> 4 acks, then rotation. Re-grant to 0 only when it is the sole requester.
//   - Backpressure: out_ready=0 for 5 cycles during BUSY.
//     -> data_out=d[sel] stable, valid=1, ack=0, beat_cnt unchanged.
//   - Abort and async reset:
//     - Drop req[sel] with out_ready=0 -> next cycle grant=0, ptr=sel+1.
//     - Pulse rst_n mid-burst -> outputs clear immediately, without a clock edge.
//   - ARB_LOCK_EN: lock[2]=1 with 6 beats.
//     -> 6 consecutive acks to requester 2, no rotation at beat 4.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 8-requester round-robin bus arbiter:
// requester count, select width, FSM state type and the one-hot helper.
package bus_arb_pkg;

   localparam int NREQ = 8;
   localparam int SELW = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Index to one-hot conversion, used for grant and ack vectors.
   function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux8x1_32bits.sv
// 8-to-1 multiplexer for 32-bit words, steered by a 3-bit control.
module mux8x1_32bits (
   input  logic [2:0]  control,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [31:0] in3,
   input  logic [31:0] in4,
   input  logic [31:0] in5,
   input  logic [31:0] in6,
   input  logic [31:0] in7,
   output logic [31:0] out
);

   // Select one input word according to control.
   always_comb begin
      out = in0;
      unique case (control)
         3'd0: out = in0;
         3'd1: out = in1;
         3'd2: out = in2;
         3'd3: out = in3;
         3'd4: out = in4;
         3'd5: out = in5;
         3'd6: out = in6;
         3'd7: out = in7;
      endcase
   end

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating priority encoder: returns the first set bit of req,
// searching ptr, ptr+1, ... modulo 8.
module rr_pick8
   import bus_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] ptr,
   output logic            found,
   output logic [SELW-1:0] idx
);

   logic [SELW-1:0] w_cand;

   // Walk the candidates from farthest to nearest so the nearest one wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      found  = 1'b0;
      idx    = ptr;
      w_cand = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = ptr + SELW'(k);
         if (req[w_cand]) begin
            found = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter8_32bits.sv
// Round-robin arbiter for eight 32-bit producers sharing one valid/ready
// consumer port. Bursts end on req_last or after MAX_BURST beats, then the
// pointer moves past the releasing requester and the next one is granted on
// the same edge. Optional macro ARB_LOCK_EN adds a lock input that lets a
// requester hold the grant beyond MAX_BURST until an unlocked last beat.
module bus_arbiter8_32bits
   import bus_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] req_last,
   input  logic [31:0]     d0,
   input  logic [31:0]     d1,
   input  logic [31:0]     d2,
   input  logic [31:0]     d3,
   input  logic [31:0]     d4,
   input  logic [31:0]     d5,
   input  logic [31:0]     d6,
   input  logic [31:0]     d7,
   input  logic            out_ready,
`ifdef ARB_LOCK_EN
   input  logic [NREQ-1:0] lock,
`endif
   output logic            out_valid,
   output logic [31:0]     data_out,
   output logic [SELW-1:0] sel,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] ack
);

   localparam int              CNTW      = $clog2(MAX_BURST) + 1;
   localparam logic [CNTW-1:0] BEAT_LAST = CNTW'(MAX_BURST - 1);
   localparam logic [CNTW-1:0] BEAT_MAX  = '1;

   arb_state_e      r_state;
   logic [NREQ-1:0] r_grant;
   logic [SELW-1:0] r_sel;
   logic [SELW-1:0] r_ptr;
   logic            r_valid;
   logic [CNTW-1:0] r_beat_cnt;

   logic            w_xfer;
   logic            w_cap;
   logic            w_release;
   logic            w_abort;
   logic [SELW-1:0] w_sel_next;
   logic [SELW-1:0] w_pick_ptr;
   logic [NREQ-1:0] w_pick_req;
   logic            w_found;
   logic [SELW-1:0] w_idx;

   assign w_xfer     = r_valid & out_ready;
   assign w_cap      = (r_beat_cnt >= BEAT_LAST);
   assign w_sel_next = r_sel + SELW'(1);

`ifdef ARB_LOCK_EN
   // A locked requester keeps the bus past the beat cap until an unlocked last beat.
   assign w_release  = w_xfer & ~lock[r_sel] & (req_last[r_sel] | w_cap);
`else
   assign w_release  = w_xfer & (req_last[r_sel] | w_cap);
`endif

   // Requester withdrew while its beat was still pending: protocol violation.
   assign w_abort    = (r_state == BUSY) & ~req[r_sel] & ~w_xfer;

   assign ack        = {NREQ{w_xfer}} & onehot(r_sel);

   // While busy, arbitration looks ahead from the pointer the release will set,
   // ignoring the requester whose beat is being acknowledged this cycle.
   assign w_pick_ptr = (r_state == BUSY) ? w_sel_next : r_ptr;
   assign w_pick_req = (r_state == BUSY) ? (req & ~ack) : req;

   rr_pick8 u_pick (
      .req   (w_pick_req),
      .ptr   (w_pick_ptr),
      .found (w_found),
      .idx   (w_idx)
   );

   mux8x1_32bits u_mux (
      .control (r_sel),
      .in0     (d0),
      .in1     (d1),
      .in2     (d2),
      .in3     (d3),
      .in4     (d4),
      .in5     (d5),
      .in6     (d6),
      .in7     (d7),
      .out     (data_out)
   );

   // Grant FSM: arbitration, burst counting, release/re-grant and abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_valid    <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         unique case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state    <= BUSY;
                  r_grant    <= onehot(w_idx);
                  r_sel      <= w_idx;
                  r_valid    <= 1'b1;
                  r_beat_cnt <= '0;
               end
            end
            BUSY: begin
               if (w_release) begin
                  r_ptr      <= w_sel_next;
                  r_beat_cnt <= '0;
                  if (w_found) begin
                     r_grant <= onehot(w_idx);
                     r_sel   <= w_idx;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= '0;
                     r_valid <= 1'b0;
                  end
               end else if (w_xfer) begin
                  if (r_beat_cnt != BEAT_MAX) begin
                     r_beat_cnt <= r_beat_cnt + CNTW'(1);
                  end
               end else if (w_abort) begin
                  r_state    <= IDLE;
                  r_grant    <= '0;
                  r_valid    <= 1'b0;
                  r_ptr      <= w_sel_next;
                  r_beat_cnt <= '0;
               end
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign grant     = r_grant;
   assign sel       = r_sel;

endmodule

// File: tb/tb_bus_arbiter8_32bits.sv
// Self-checking bench for bus_arbiter8_32bits: directed scenarios followed by
// randomized traffic, all compared against a behavioural round-robin model.
// Define ARB_LOCK_EN to also exercise the lock feature.
module tb_bus_arbiter8_32bits;

   localparam int MAX_BURST = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  req;
   logic [7:0]  req_last;
   logic [31:0] d [8];
   logic        out_ready;
`ifdef ARB_LOCK_EN
   logic [7:0]  lock;
`endif
   logic        out_valid;
   logic [31:0] data_out;
   logic [2:0]  sel;
   logic [7:0]  grant;
   logic [7:0]  ack;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state: who holds the bus, the rotation pointer, beats done.
   bit m_busy;
   int m_sel;
   int m_ptr;
   int m_beats;

   bus_arbiter8_32bits #(.MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_last  (req_last),
      .d0        (d[0]),
      .d1        (d[1]),
      .d2        (d[2]),
      .d3        (d[3]),
      .d4        (d[4]),
      .d5        (d[5]),
      .d6        (d[6]),
      .d7        (d[7]),
      .out_ready (out_ready),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .out_valid (out_valid),
      .data_out  (data_out),
      .sel       (sel),
      .grant     (grant),
      .ack       (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
      m_beats = 0;
   endtask

   // Settle after the input change, then compare all outputs to the model.
   task automatic compare_outputs(input string tag);
      logic [7:0] e_grant;
      logic [7:0] e_ack;
      #1;
      e_grant = m_busy ? (8'd1 << m_sel) : 8'd0;
      e_ack   = (m_busy && out_ready) ? (8'd1 << m_sel) : 8'd0;
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
      chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
      chk({tag, ".sel"},   32'(sel), 32'(m_sel));
      chk({tag, ".ack"},   32'(ack), 32'(e_ack));
      chk({tag, ".data"},  data_out, d[m_sel]);
   endtask

   // Apply the arbitration rules to the current inputs, then clock once.
   task automatic advance();
      logic [7:0] masked;
      int         nxt;
      bit         lk;
      bit         rel;
      lk = 1'b0;
`ifdef ARB_LOCK_EN
      lk = lock[m_sel];
`endif
      if (!m_busy) begin
         nxt = first_from(req, m_ptr);
         if (nxt >= 0) begin
            m_busy  = 1'b1;
            m_sel   = nxt;
            m_beats = 0;
         end
      end else if (out_ready) begin
         m_beats++;
         rel = !lk && (req_last[m_sel] || m_beats >= MAX_BURST);
         if (rel) begin
            m_ptr   = (m_sel + 1) % 8;
            m_beats = 0;
            masked  = req & ~(8'd1 << m_sel);
            nxt     = first_from(masked, m_ptr);
            if (nxt >= 0) m_sel = nxt;
            else          m_busy = 1'b0;
         end
      end else if (!req[m_sel]) begin
         m_busy  = 1'b0;
         m_ptr   = (m_sel + 1) % 8;
         m_beats = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input string tag);
      compare_outputs(tag);
      advance();
   endtask

   initial begin
      logic [31:0] held;
      logic [7:0]  r;

      rst_n     = 1'b0;
      req       = '0;
      req_last  = '0;
      out_ready = 1'b0;
`ifdef ARB_LOCK_EN
      lock      = '0;
`endif
      for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + 32'(i);
      model_reset();

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst.grant", 32'(grant), 32'h0);
      chk("rst.valid", 32'(out_valid), 32'h0);
      chk("rst.sel",   32'(sel), 32'h0);
      chk("rst.ack",   32'(ack), 32'h0);

      // Release with requester 4 asking: granted one cycle later.
      @(negedge clk);
      rst_n = 1'b1;
      req   = 8'h10;
      step("first_idle");
      compare_outputs("first_grant");
      chk("first_grant.const", 32'(grant), 32'h10);
      chk("first_sel.const",   32'(sel), 32'h4);
      chk("first_valid.const", 32'(out_valid), 32'h1);
      req_last  = 8'h10;
      out_ready = 1'b1;
      advance();
      req = '0;
      repeat (2) step("drain");

      // Fairness: everyone asks, single-beat bursts.
      req      = 8'hFF;
      req_last = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         compare_outputs("fair");
         if (i > 0) begin
            chk("fair.onehot", 32'($onehot(ack)), 32'h1);
            chk("fair.valid",  32'(out_valid), 32'h1);
         end
         advance();
      end
      req = '0;
      repeat (3) step("drain");

      // Burst cap: requester 0 alone with no last marker, then a competitor.
      req      = 8'h01;
      req_last = 8'h00;
      for (int i = 0; i < 12; i++) step("cap_solo");
      req = 8'h03;
      for (int i = 0; i < 12; i++) step("cap_pair");
      req = '0;
      repeat (3) step("drain");

      // Backpressure: data stays put while the consumer stalls.
      req       = 8'h04;
      out_ready = 1'b0;
      step("bp_grant");
      held = data_out;
      for (int i = 0; i < 5; i++) begin
         compare_outputs("bp");
         chk("bp.stable", data_out, held);
         chk("bp.noack",  32'(ack), 32'h0);
         advance();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step("bp_resume");
      req = '0;
      repeat (3) step("drain");

      // Abort: requester 3 withdraws while stalled; pointer moves to 4.
      req       = 8'h08;
      out_ready = 1'b0;
      step("abort_grant");
      step("abort_hold");
      req = 8'h00;
      step("abort_drop");
      compare_outputs("abort_idle");
      chk("abort.grant", 32'(grant), 32'h0);
      req = 8'h0C;
      advance();
      compare_outputs("abort_regrant");
      chk("abort.ptr_sel", 32'(sel), 32'h2);

      // Asynchronous reset mid-burst: outputs clear without a clock edge.
      out_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async.valid", 32'(out_valid), 32'h0);
      chk("async.grant", 32'(grant), 32'h0);
      chk("async.ack",   32'(ack), 32'h0);
      chk("async.sel",   32'(sel), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      req   = '0;
      step("post_rst");

`ifdef ARB_LOCK_EN
      // Locked requester 2 takes six beats without rotation at beat four.
      req       = 8'h07;
      req_last  = 8'h00;
      lock      = 8'h04;
      out_ready = 1'b0;
      req       = 8'h04;
      step("lock_grant");
      req       = 8'h07;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            req_last = 8'h04;
            lock     = 8'h00;
         end
         compare_outputs("lock");
         chk("lock.ack", 32'(ack), 32'h04);
         advance();
      end
      req_last = 8'h00;
      lock     = 8'h00;
      req      = '0;
      repeat (4) step("drain");
`endif

      // Randomized traffic; the current holder usually keeps asking.
      for (int i = 0; i < 400; i++) begin
         r = 8'($urandom);
         if (m_busy && $urandom_range(0, 9) != 0) r[m_sel] = 1'b1;
         req       = r;
         req_last  = 8'($urandom) & 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
         lock      = 8'($urandom) & 8'($urandom) & 8'($urandom);
`endif
         for (int k = 0; k < 8; k++) d[k] = $urandom;
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
